word_transmitter: RTL and testbench
===================================

Name: word_transmitter

Overview:
- Byte-serial transmitter for the string-hash link. On a Start request it emits one of three stored words, one character per accepted transfer, onto the 8-bit character stream that the word detector consumes.
- An optional separator character follows each word. The separator forces the detector's match counters back to zero, so back-to-back words stay detectable.
- Word select uses the detector's Wfound one-hot encoding. A detected word can therefore be retransmitted directly.

Parameters:
- W1, "HASHES", word 1 characters; leftmost character is sent first, packed in the MSBs.
- W1_LEN, 6, number of characters in W1 (1..8).
- W2, "STRINGS", word 2 characters.
- W2_LEN, 7, number of characters in W2 (1..8).
- W3, "SIGNALS", word 3 characters.
- W3_LEN, 7, number of characters in W3 (1..8).
- SEND_SEP, 1, 1 = append the separator after each word.
- SEP_CHAR, 8'h20, separator character.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  transmit request; sampled only in IDLE.
- Sel  in  3  one-hot word select: bit2 = W1, bit1 = W2, bit0 = W3.
- XReady  in  1  sink accepts the current character.
- X  out  8  character output.
- XValid  out  1  X holds a valid character.
- Busy  out  1  transmission in progress.
- Done  out  1  one-cycle pulse when a word (plus separator) has completed.
- Err  out  1  one-cycle pulse when Start arrives with an illegal Sel.

Behaviour:
- Reset: asserts asynchronously. It forces state = IDLE, X = 8'h00, XValid = 0, Busy = 0, Done = 0, Err = 0, and clears the index and latched select.
  - Reset mid-word aborts the word. No partial completion is signalled.
- States: IDLE, SEND, SEP.
- IDLE:
  - Start = 1 with Sel one-hot: latch Sel, set index = 0, go to SEND. XValid = 1 with character 0 on the next cycle.
  - Start = 1 with Sel not one-hot (000, or two or more bits set): stay in IDLE, Err = 1 for one cycle.
  - Start = 0: remain in IDLE.
- SEND:
  - X = byte index i of the selected word, i.e. W[8*(LEN-i)-1 -: 8]. XValid = 1.
  - A transfer occurs on a rising edge with XValid & XReady; i increments.
  - XReady = 0: X and XValid hold stable, with no limit on stall length.
  - Transfer of i = LEN-1 with SEND_SEP = 1: go to SEP.
  - Transfer of i = LEN-1 with SEND_SEP = 0: go to IDLE with Done = 1.
- SEP:
  - X = SEP_CHAR, XValid = 1.
  - On transfer: go to IDLE, Done = 1 for one cycle.
- Busy = (state != IDLE).
- Start and Sel are ignored while Busy; no queueing.
- Done and the return to IDLE occur in the same cycle. A Start in that cycle is accepted, so back-to-back words have zero idle cycles.
- When XValid = 0, X = 8'h00.
- Throughput: 1 character per cycle with XReady held high. A word costs LEN + SEND_SEP cycles plus 1 Start cycle.
- The index counter is 3 bits. It never exceeds LEN-1 and never wraps.
- Sel is latched at Start; later changes to Sel do not affect the word in progress.
- All outputs are registered.

Test Plan:
- Reset_n low, then high; Start = 1, Sel = 3'b100; XReady = 1 -> X sequence 48,41,53,48,45,53,20 on consecutive cycles with XValid = 1; Done pulse 1 cycle after the last transfer; total 8 cycles from Start to Done.
- Sel = 3'b001 with XReady toggled 1,0,1,0,... -> each character of "SIGNALS" (53,49,47,4E,41,4C,53) holds on X while XReady = 0; no character is skipped or duplicated; the 20 separator follows.
- Start with Sel = 3'b000, then Sel = 3'b110 -> Err pulses, XValid stays 0, Busy stays 0.
- Start in the Done cycle with Sel = 3'b010 -> "STRINGS" (53,54,52,49,4E,47,53) begins the next cycle with no gap; Start pulses during transmission are ignored.
- Reset_n low after the 3rd character of W2 -> XValid = 0 and Busy = 0 immediately (asynchronously); no Done; after release, a new Start sends from character 0.
- SEND_SEP = 0 build, loop the output into the word detector -> detector Wfound = 3'b100 after "HASHES" without a separator; with SEND_SEP = 1, two consecutive words are both detected.

Source files
------------

// File: rtl/word_transmitter_if.sv
// ============================================================================
// Module      : word_transmitter_if
// Description : Character stream (X / XValid / XReady) between transmitter and sink.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface word_transmitter_if;
    logic [7:0] X;
    logic       XValid;
    logic       XReady;

    modport master (
        output X,
        output XValid,
        input  XReady
    );

    modport slave (
        input  X,
        input  XValid,
        output XReady
    );
endinterface

`default_nettype wire

// File: rtl/word_transmitter.sv
// ============================================================================
// Module      : word_transmitter
// Description : Sends one of three stored words, byte-serially, plus optional separator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module word_transmitter #(
    parameter logic [63:0] W1       = {16'h0000, "HASHES"},
    parameter int          W1_LEN   = 6,
    parameter logic [63:0] W2       = {8'h00, "STRINGS"},
    parameter int          W2_LEN   = 7,
    parameter logic [63:0] W3       = {8'h00, "SIGNALS"},
    parameter int          W3_LEN   = 7,
    parameter int          SEND_SEP = 1,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  wire logic       Clock,
    input  wire logic       Reset_n,
    input  wire logic       Start,
    input  wire logic [2:0] Sel,
    word_transmitter_if.master tx,
    output logic            Busy,
    output logic            Done,
    output logic            Err
);

    localparam logic [3:0] c_W1_LEN   = 4'(W1_LEN);
    localparam logic [3:0] c_W2_LEN   = 4'(W2_LEN);
    localparam logic [3:0] c_W3_LEN   = 4'(W3_LEN);
    localparam bit         c_SEND_SEP = (SEND_SEP != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_SEP  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [2:0] r_sel;

    logic       w_sel_ok;
    logic [2:0] w_last_idx;
    logic [7:0] w_first_char;
    logic [7:0] w_next_char;

    function automatic logic [3:0] f_len(input logic [2:0] sel);
        logic [3:0] len;
        len = 4'd1;
        case (sel)
            3'b100:  len = c_W1_LEN;
            3'b010:  len = c_W2_LEN;
            3'b001:  len = c_W3_LEN;
            default: len = 4'd1;
        endcase
        return len;
    endfunction

    // Character idx counts from the left end of the word, so the shift is taken
    // from the word length rather than from the 64-bit container width.
    function automatic logic [7:0] f_char(input logic [2:0] sel, input logic [2:0] idx);
        logic [63:0] word;
        logic [3:0]  pos;
        logic [5:0]  sh;
        case (sel)
            3'b100:  word = W1;
            3'b010:  word = W2;
            3'b001:  word = W3;
            default: word = 64'd0;
        endcase
        pos  = f_len(sel) - 4'd1 - {1'b0, idx};
        sh   = {pos[2:0], 3'b000};
        word = word >> sh;
        return word[7:0];
    endfunction

    always_comb begin
        w_sel_ok = 1'b0;
        case (Sel)
            3'b100, 3'b010, 3'b001: w_sel_ok = 1'b1;
            default:                w_sel_ok = 1'b0;
        endcase
    end

    logic [3:0] w_len_latched;
    assign w_len_latched = f_len(r_sel) - 4'd1;
    assign w_last_idx    = w_len_latched[2:0];
    assign w_first_char  = f_char(Sel, 3'd0);
    assign w_next_char   = f_char(r_sel, r_idx + 3'd1);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_sel     <= 3'd0;
            tx.X      <= 8'h00;
            tx.XValid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (w_sel_ok) begin
                            r_sel     <= Sel;
                            r_idx     <= 3'd0;
                            tx.X      <= w_first_char;
                            tx.XValid <= 1'b1;
                            Busy      <= 1'b1;
                            r_state   <= S_SEND;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    if (tx.XReady) begin
                        if (r_idx != w_last_idx) begin
                            r_idx <= r_idx + 3'd1;
                            tx.X  <= w_next_char;
                        end else if (c_SEND_SEP) begin
                            tx.X    <= SEP_CHAR;
                            r_state <= S_SEP;
                        end else begin
                            r_state   <= S_IDLE;
                            r_idx     <= 3'd0;
                            tx.X      <= 8'h00;
                            tx.XValid <= 1'b0;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                        end
                    end
                end

                S_SEP: begin
                    if (tx.XReady) begin
                        r_state   <= S_IDLE;
                        r_idx     <= 3'd0;
                        tx.X      <= 8'h00;
                        tx.XValid <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_idx     <= 3'd0;
                    tx.X      <= 8'h00;
                    tx.XValid <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_word_transmitter.sv
// ============================================================================
// Module      : tb_word_transmitter
// Description : Directed self-checking bench for word_transmitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_word_transmitter;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start   = 1'b0;
    logic [2:0] Sel     = 3'b000;
    logic       XReady  = 1'b0;

    logic Busy1, Done1, Err1;
    logic Busy2, Done2, Err2;

    int checks = 0;
    int errors = 0;

    logic [7:0] e_hash [8];
    logic [7:0] e_str  [8];
    logic [7:0] e_sig  [8];

    word_transmitter_if s1 ();
    word_transmitter_if s2 ();

    assign s1.XReady = XReady;
    assign s2.XReady = XReady;

    always #5 Clock = ~Clock;

    word_transmitter u_dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Sel     (Sel),
        .tx      (s1.master),
        .Busy    (Busy1),
        .Done    (Done1),
        .Err     (Err1)
    );

    word_transmitter #(.SEND_SEP(0)) u_dut_nosep (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Sel     (Sel),
        .tx      (s2.master),
        .Busy    (Busy2),
        .Done    (Done2),
        .Err     (Err2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        e_hash = '{8'h48, 8'h41, 8'h53, 8'h48, 8'h45, 8'h53, 8'h20, 8'h00};
        e_str  = '{8'h53, 8'h54, 8'h52, 8'h49, 8'h4E, 8'h47, 8'h53, 8'h20};
        e_sig  = '{8'h53, 8'h49, 8'h47, 8'h4E, 8'h41, 8'h4C, 8'h53, 8'h20};

        // Reset state
        repeat (2) @(negedge Clock);
        chk("rst_x",      s1.X,             8'h00);
        chk("rst_xvalid", {7'd0, s1.XValid}, 8'h00);
        chk("rst_busy",   {7'd0, Busy1},     8'h00);
        chk("rst_done",   {7'd0, Done1},     8'h00);
        chk("rst_err",    {7'd0, Err1},      8'h00);
        chk("rst_x2",     s2.X,             8'h00);
        chk("rst_busy2",  {7'd0, Busy2},     8'h00);
        chk("rst_err2",   {7'd0, Err2},      8'h00);
        Reset_n = 1'b1;

        // W1 with XReady high; no-separator instance runs alongside
        @(negedge Clock);
        Start = 1'b1; Sel = 3'b100; XReady = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("w1_x",      s1.X,              e_hash[k]);
            chk("w1_xvalid", {7'd0, s1.XValid},  8'h01);
            chk("w1_busy",   {7'd0, Busy1},      8'h01);
            chk("w1_done",   {7'd0, Done1},      8'h00);
            if (k < 6) begin
                chk("nosep_x", s2.X, e_hash[k]);
            end else begin
                chk("nosep_done",   {7'd0, Done2},     8'h01);
                chk("nosep_xvalid", {7'd0, s2.XValid}, 8'h00);
                chk("nosep_x_idle", s2.X,             8'h00);
            end
            @(negedge Clock);
        end
        chk("w1_done_pulse", {7'd0, Done1},     8'h01);
        chk("w1_end_xvalid", {7'd0, s1.XValid}, 8'h00);
        chk("w1_end_x",      s1.X,             8'h00);
        chk("w1_end_busy",   {7'd0, Busy1},     8'h00);
        @(negedge Clock);
        chk("w1_done_once",  {7'd0, Done1},     8'h00);
        chk("nosep_done_once", {7'd0, Done2},   8'h00);

        // W3 with XReady toggling; Sel changed mid-word must not matter
        Start = 1'b1; Sel = 3'b001; XReady = 1'b0;
        @(negedge Clock);
        Start = 1'b0; Sel = 3'b100;
        for (int k = 0; k < 8; k++) begin
            chk("w3_x",      s1.X, e_sig[k]);
            XReady = 1'b0;
            @(negedge Clock);
            chk("w3_hold_x", s1.X, e_sig[k]);
            chk("w3_hold_v", {7'd0, s1.XValid}, 8'h01);
            XReady = 1'b1;
            @(negedge Clock);
        end
        chk("w3_done", {7'd0, Done1}, 8'h01);
        chk("w3_idle", {7'd0, Busy1}, 8'h00);

        // Illegal selects
        Start = 1'b1; Sel = 3'b000;
        @(negedge Clock);
        chk("err000",        {7'd0, Err1},      8'h01);
        chk("err000_xvalid", {7'd0, s1.XValid}, 8'h00);
        chk("err000_busy",   {7'd0, Busy1},     8'h00);
        Sel = 3'b110;
        @(negedge Clock);
        chk("err110",        {7'd0, Err1},      8'h01);
        chk("err110_xvalid", {7'd0, s1.XValid}, 8'h00);
        chk("err110_busy",   {7'd0, Busy1},     8'h00);
        Start = 1'b0;
        @(negedge Clock);
        chk("err_clear",     {7'd0, Err1},      8'h00);

        // W1, then Start in the Done cycle for W2; stray Starts while busy
        Start = 1'b1; Sel = 3'b100;
        @(negedge Clock);
        Start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("b2b_w1_x", s1.X, e_hash[k]);
            if (k == 2) begin
                Start = 1'b1; Sel = 3'b001;
            end else if (k == 3) begin
                Start = 1'b0;
            end
            @(negedge Clock);
        end
        chk("b2b_done1", {7'd0, Done1}, 8'h01);
        Start = 1'b1; Sel = 3'b010;
        @(negedge Clock);
        Start = 1'b0; Sel = 3'b000;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_w2_x", s1.X,              e_str[k]);
            chk("b2b_w2_v", {7'd0, s1.XValid},  8'h01);
            if (k == 4) Start = 1'b1;
            if (k == 5) Start = 1'b0;
            @(negedge Clock);
        end
        chk("b2b_done2", {7'd0, Done1}, 8'h01);
        @(negedge Clock);
        chk("b2b_no_queue_busy", {7'd0, Busy1},     8'h00);
        chk("b2b_no_queue_v",    {7'd0, s1.XValid}, 8'h00);

        // Asynchronous reset mid-W2, then a clean restart
        Start = 1'b1; Sel = 3'b010;
        @(negedge Clock);
        Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort_pre_x", s1.X, e_str[k]);
            @(negedge Clock);
        end
        chk("abort_at_x", s1.X, e_str[3]);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_xvalid", {7'd0, s1.XValid}, 8'h00);
        chk("abort_busy",   {7'd0, Busy1},     8'h00);
        chk("abort_x",      s1.X,             8'h00);
        @(negedge Clock);
        chk("abort_no_done", {7'd0, Done1}, 8'h00);
        Reset_n = 1'b1;
        @(negedge Clock);
        chk("abort_no_done2", {7'd0, Done1}, 8'h00);
        chk("abort_idle",     {7'd0, Busy1}, 8'h00);
        Start = 1'b1; Sel = 3'b010;
        @(negedge Clock);
        Start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("restart_x", s1.X, e_str[k]);
            @(negedge Clock);
        end
        chk("restart_done", {7'd0, Done1}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
